gray_stream_monitor: RTL
========================

# gray_stream_monitor

Downstream consumer of the binary-to-Gray converter. Accepts a stream of WIDTH-bit Gray codes, decodes each to binary, and checks that successive codes form a legal single-step sequence (±1 modulo 2^WIDTH). Reports direction and step errors, keeps a saturating error count, and latches a fault after a run of consecutive bad steps. Used to self-check Gray counters and encoder interfaces on the same board.

## Interface
- WIDTH, 4: Gray/binary code width.
- ERR_CNT_W, 8: width of the error counter.
- FAULT_LIMIT, 3: consecutive errors that force FAULT, range 1..7.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_gray is valid this cycle; always accepted, no backpressure.
- in_gray  in  WIDTH  Gray-coded sample.
- clr_fault  in  1  single-cycle pulse: clear fault, counters and history.
- out_valid  out  1  registered outputs below describe a sample accepted last cycle.
- out_bin  out  WIDTH  decoded binary of that sample.
- out_step  out  1  sample was a legal ±1 move.
- out_dir  out  1  1 = up, 0 = down; meaningful only with out_step.
- out_err  out  1  sample was an illegal move.
- err_count  out  ERR_CNT_W  total errors since reset or clear; saturates at all-ones.
- fault  out  1  high while in FAULT.

## Operation
- Decode: bin[WIDTH-1] = g[WIDTH-1]; bin[i] = bin[i+1] ^ g[i].
- States: EMPTY (no previous sample), TRACK, FAULT. Reset → EMPTY.
- EMPTY, in_valid: store gray/bin as previous. out_valid=1, out_step=0, out_err=0. → TRACK.
- TRACK, in_valid: compute diff = bin − prev_bin mod 2^WIDTH.
  - diff = 0: repeat. out_step=0, out_err=0, out_dir unchanged, consec cleared.
  - diff = 1: out_step=1, out_dir=1, consec cleared.
  - diff = 2^WIDTH−1: out_step=1, out_dir=0, consec cleared.
  - any other: out_err=1, err_count +1 (saturating), consec +1. Previous sample is updated to the new sample.
  - When consec reaches FAULT_LIMIT in this cycle → FAULT.
- FAULT: in_valid ignored (out_valid=0), fault=1, err_count frozen. Leaves only by clr_fault or rst.
- clr_fault in any state: next state EMPTY, err_count=0, consec=0, fault=0, out_dir=0. A sample in the same cycle is discarded (out_valid=0).
- rst beats clr_fault. clr_fault beats in_valid.
- Single-bit Gray changes are not automatically legal. Example: 0000→0010 decodes 0→3 and is an error. Only the binary ±1 rule applies.

## Timing
- All outputs registered. Latency is 1 cycle from the in_valid edge to out_valid.
- Full throughput: one sample per cycle, back-to-back.
- Reset values: out_valid=0, out_bin=0, out_step=0, out_dir=0, out_err=0, err_count=0, fault=0, consec=0, state=EMPTY.
- out_valid, out_step and out_err are one-cycle pulses, low in any cycle without an accepted sample. out_bin and out_dir hold their last value.
- fault rises in the same cycle as the out_err pulse of the FAULT_LIMIT-th consecutive error, and falls the cycle after clr_fault.
- Wrap: 1000→0000 (15→0) is up. 0000→1000 is down.
- Reset while streaming: the next cycle shows reset values. The first sample after reset is treated as an EMPTY capture.

## Structure
- Shared package gray_pkg:
  - state encoding constants EMPTY=2'd0, TRACK=2'd1, FAULT=2'd2;
  - default WIDTH;
  - gray-to-binary function.
- One sub-module, gray_to_binary: parameterised combinational prefix-XOR decoder, the inverse of the team's binary-to-Gray converter.
- The top holds the FSM, previous-sample registers, consecutive and error counters, and output registers.

## Test plan
- Up run: after reset, in_gray 0000, 0001, 0011, 0010 on consecutive cycles → out_bin 0,1,2,3. First sample has out_step=0; the rest have out_step=1, out_dir=1. err_count=0.
- Down wrap: 0000 then 1000 → out_bin 15, out_step=1, out_dir=0. Repeat 1000 → out_step=0, out_err=0.
- Illegal single-bit move: 0000 then 0010 → out_err=1, out_bin=3, err_count=1. Then 0110 (4) → out_step=1, out_dir=1, consec cleared.
- Fault: 0000, 0011, 0000, 0011 → fault=1 with the third out_err. A further in_valid gives no out_valid. clr_fault → fault=0, err_count=0; the next sample is an EMPTY capture.
- Saturation: ERR_CNT_W=2, FAULT_LIMIT=7, six errors interleaved with legal steps → err_count stays 3, fault=0.
- Priority: clr_fault together with in_valid → out_valid=0 next cycle. rst together with clr_fault and in_valid → all reset values.

Source files
------------

// File: rtl/gray_pkg.sv
// gray_pkg: shared definitions for the Gray stream monitor.
//   - default code width
//   - FSM state encoding
//   - gray2bin(): reference Gray-to-binary decode for up to 32-bit codes
//     (narrower codes are zero-extended, which decodes identically)
package gray_pkg;

    localparam int GRAY_WIDTH = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_to_binary.sv
// gray_to_binary: combinational Gray-to-binary decoder (inverse of the
// binary-to-Gray converter). Each binary bit is the XOR of all Gray bits
// at or above its position.
//   i_gray  in   WIDTH  Gray-coded value
//   o_bin   out  WIDTH  decoded binary value
module gray_to_binary #(
    parameter int WIDTH = gray_pkg::GRAY_WIDTH
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign o_bin[i] = ^(i_gray >> i);
    end

endmodule

// File: rtl/gray_stream_monitor.sv
// gray_stream_monitor: decodes a stream of Gray codes and checks that each
// sample is a legal +/-1 (mod 2^WIDTH) move from the previous one.
//   clk        in   1          rising-edge clock
//   rst        in   1          synchronous active-high reset
//   in_valid   in   1          in_gray valid (always accepted)
//   in_gray    in   WIDTH      Gray-coded sample
//   clr_fault  in   1          clear fault, counters and history
//   out_valid  out  1          outputs describe last cycle's sample
//   out_bin    out  WIDTH      decoded binary of that sample
//   out_step   out  1          legal +/-1 move
//   out_dir    out  1          1 = up, 0 = down (valid with out_step)
//   out_err    out  1          illegal move
//   err_count  out  ERR_CNT_W  saturating error count
//   fault      out  1          FAULT_LIMIT consecutive errors seen
module gray_stream_monitor
    import gray_pkg::*;
#(
    parameter int WIDTH       = GRAY_WIDTH,
    parameter int ERR_CNT_W   = 8,
    parameter int FAULT_LIMIT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_gray,
    input  logic                 clr_fault,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_bin,
    output logic                 out_step,
    output logic                 out_dir,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 fault
);

    localparam logic [WIDTH-1:0]     STEP_UP = WIDTH'(1);
    localparam logic [WIDTH-1:0]     STEP_DN = '1;
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;
    localparam logic [2:0]           LIMIT   = 3'(FAULT_LIMIT);

    state_t                 r_state, w_state_nxt;
    logic [WIDTH-1:0]       r_prev_bin, w_prev_nxt;
    logic [2:0]             r_consec, w_consec_nxt, w_consec_inc;
    logic [ERR_CNT_W-1:0]   r_err_cnt, w_cnt_nxt;
    logic                   r_out_valid, w_valid_nxt;
    logic [WIDTH-1:0]       r_out_bin, w_bin_nxt;
    logic                   r_out_step, w_step_nxt;
    logic                   r_out_dir, w_dir_nxt;
    logic                   r_out_err, w_err_nxt;
    logic [WIDTH-1:0]       w_bin;
    logic [WIDTH-1:0]       w_diff;

    gray_to_binary #(.WIDTH(WIDTH)) u_dec (
        .i_gray (in_gray),
        .o_bin  (w_bin)
    );

    // Modular difference: 1 means up, all-ones means down (covers wrap).
    assign w_diff       = w_bin - r_prev_bin;
    assign w_consec_inc = r_consec + 3'd1;

    always_ff @(posedge clk) begin
        if (rst) r_state <= EMPTY;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_prev_nxt   = r_prev_bin;
        w_consec_nxt = r_consec;
        w_cnt_nxt    = r_err_cnt;
        w_valid_nxt  = 1'b0;
        w_bin_nxt    = r_out_bin;
        w_step_nxt   = 1'b0;
        w_dir_nxt    = r_out_dir;
        w_err_nxt    = 1'b0;

        if (clr_fault) begin
            // Clear wins over a same-cycle sample, which is dropped.
            w_state_nxt  = EMPTY;
            w_consec_nxt = 3'd0;
            w_cnt_nxt    = '0;
            w_dir_nxt    = 1'b0;
        end else begin
            case (r_state)
                EMPTY: if (in_valid) begin
                    w_valid_nxt = 1'b1;
                    w_bin_nxt   = w_bin;
                    w_prev_nxt  = w_bin;
                    w_state_nxt = TRACK;
                end
                TRACK: if (in_valid) begin
                    w_valid_nxt = 1'b1;
                    w_bin_nxt   = w_bin;
                    w_prev_nxt  = w_bin;
                    if (w_diff == '0) begin
                        w_consec_nxt = 3'd0;
                    end else if (w_diff == STEP_UP) begin
                        w_step_nxt   = 1'b1;
                        w_dir_nxt    = 1'b1;
                        w_consec_nxt = 3'd0;
                    end else if (w_diff == STEP_DN) begin
                        w_step_nxt   = 1'b1;
                        w_dir_nxt    = 1'b0;
                        w_consec_nxt = 3'd0;
                    end else begin
                        w_err_nxt    = 1'b1;
                        w_consec_nxt = w_consec_inc;
                        if (r_err_cnt != CNT_MAX)
                            w_cnt_nxt = r_err_cnt + ERR_CNT_W'(1);
                        if (w_consec_inc >= LIMIT)
                            w_state_nxt = FAULT;
                    end
                end
                FAULT: ;  // samples ignored, counters frozen
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_bin  <= '0;
            r_consec    <= 3'd0;
            r_err_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_bin   <= '0;
            r_out_step  <= 1'b0;
            r_out_dir   <= 1'b0;
            r_out_err   <= 1'b0;
        end else begin
            r_prev_bin  <= w_prev_nxt;
            r_consec    <= w_consec_nxt;
            r_err_cnt   <= w_cnt_nxt;
            r_out_valid <= w_valid_nxt;
            r_out_bin   <= w_bin_nxt;
            r_out_step  <= w_step_nxt;
            r_out_dir   <= w_dir_nxt;
            r_out_err   <= w_err_nxt;
        end
    end

    assign out_valid = r_out_valid;
    assign out_bin   = r_out_bin;
    assign out_step  = r_out_step;
    assign out_dir   = r_out_dir;
    assign out_err   = r_out_err;
    assign err_count = r_err_cnt;
    assign fault     = (r_state == FAULT);

endmodule
